// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential Vedic multiply-accumulate engine.
package vedic_pkg;

  localparam int W_DEFAULT = 8;
  localparam int MUL_STEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

endpackage

// File: rtl/vedic_mul_half.sv
// Combinational HxH Urdhva-Tiryagbhyam multiplier: crosswise column sums
// resolved LSB-first with a rippling column carry.
module vedic_mul_half #(
  parameter int H = 4
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-1:0] p
);

  // Wide enough for the largest column carry (bounded by the full product).
  localparam int SW = 2 * H + 1;

  logic [SW-1:0] col;
  logic [SW-1:0] carry;

  always_comb begin
    p     = '0;
    col   = '0;
    carry = '0;
    for (int k = 0; k < 2 * H; k++) begin
      col = carry;
      for (int i = 0; i < H; i++) begin
        for (int j = 0; j < H; j++) begin
          if (i + j == k) begin
            col = col + SW'(x[i] & y[j]);
          end
        end
      end
      p[k]  = col[0];
      carry = col >> 1;
    end
  end

endmodule

// File: rtl/vedic_mul_acc_seq.sv
// Sequential a*b + addend engine: one half-width Vedic multiplier time-shared
// over four cycles, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | accumulating one partial product per cycle, step 0..3
// DONE  | product held, out_valid high until consumer accepts
module vedic_mul_acc_seq
  import vedic_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   addend,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product
);

  localparam int H = W / 2;

  state_t         state;
  step_t          step;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc;

  logic [H-1:0]   mul_x;
  logic [H-1:0]   mul_y;
  logic [2*H-1:0] mul_p;
  logic [2*W-1:0] pp_ext;
  logic [2*W-1:0] pp_add;

  // Operand-half selection and partial-product alignment per step.
  always_comb begin
    mul_x  = a_q[H-1:0];
    mul_y  = b_q[H-1:0];
    pp_ext = (2 * W)'(mul_p);
    pp_add = pp_ext;
    case (step)
      2'd0: begin
        mul_x  = a_q[H-1:0];
        mul_y  = b_q[H-1:0];
        pp_add = pp_ext;
      end
      2'd1: begin
        mul_x  = a_q[H-1:0];
        mul_y  = b_q[W-1:H];
        pp_add = pp_ext << H;
      end
      2'd2: begin
        mul_x  = a_q[W-1:H];
        mul_y  = b_q[H-1:0];
        pp_add = pp_ext << H;
      end
      default: begin
        mul_x  = a_q[W-1:H];
        mul_y  = b_q[W-1:H];
        pp_add = pp_ext << (2 * H);
      end
    endcase
  end

  vedic_mul_half #(.H(H)) u_mul_half (
    .x (mul_x),
    .y (mul_y),
    .p (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= (2 * W)'(addend);
            step     <= '0;
            state    <= MUL;
            in_ready <= 1'b0;
          end
        end
        MUL: begin
          acc  <= acc + pp_add;
          step <= step + 2'd1;
          if (step == step_t'(MUL_STEPS - 1)) begin
            step      <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // No input accept here: in_ready only returns once back in IDLE.
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          step      <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign product = acc;

endmodule
